// File: rtl/sparc_mem_unit.sv
// Byte-addressed big-endian data/instruction memory with an MFA/MFC
// handshake, programmable wait states, SPARC load/store size decoding,
// sign/zero extension and misalignment/illegal-opcode error reporting.
module sparc_mem_unit #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              MFA,
    input  logic [5:0]        Opcode,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       DataIn,
    output logic [31:0]       DataOut,
    output logic              MFC,
    output logic              Err
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    // Access size codes: number of bytes is 1 << size
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [5:0]        op_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       din_reg;
    logic [31:0]       dout_reg;
    logic              err_reg, err_next;
    logic              latch_en;
    logic              do_access;

    logic [7:0]        mem [DEPTH];

    // In IDLE the request is taken straight from the ports (zero-wait
    // accesses complete on the request edge); later the latched copy is used.
    logic [5:0]        acc_op;
    logic [ADDR_W-1:0] acc_addr;
    logic [31:0]       acc_data;

    assign acc_op   = (state_reg == IDLE) ? Opcode  : op_reg;
    assign acc_addr = (state_reg == IDLE) ? Address : addr_reg;
    assign acc_data = (state_reg == IDLE) ? DataIn  : din_reg;

    logic       legal, is_store, is_signed, misaligned, acc_err;
    logic [1:0] size_code;

    // Opcode decode into size, direction and signedness
    always_comb begin
        legal     = 1'b1;
        is_store  = 1'b0;
        is_signed = 1'b0;
        size_code = SZ_BYTE;
        case (acc_op)
            6'b000000: size_code = SZ_WORD;
            6'b000001: size_code = SZ_BYTE;
            6'b000010: size_code = SZ_HALF;
            6'b001001: begin size_code = SZ_BYTE; is_signed = 1'b1; end
            6'b001010: begin size_code = SZ_HALF; is_signed = 1'b1; end
            6'b000100: begin size_code = SZ_WORD; is_store  = 1'b1; end
            6'b000101: begin size_code = SZ_BYTE; is_store  = 1'b1; end
            6'b000110: begin size_code = SZ_HALF; is_store  = 1'b1; end
            default:   legal = 1'b0;
        endcase
    end

    assign misaligned = ((size_code == SZ_WORD) && (acc_addr[1:0] != 2'b00)) ||
                        ((size_code == SZ_HALF) && acc_addr[0]);
    assign acc_err    = !legal || misaligned;

    // Handshake FSM: next state, wait counter and error flag
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        err_next   = err_reg;
        latch_en   = 1'b0;
        do_access  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (MFA) begin
                    latch_en = 1'b1;
                    if (acc_err) begin
                        state_next = DONE;
                        err_next   = 1'b1;
                    end else if (WAIT_CYCLES > 0) begin
                        state_next = BUSY;
                        cnt_next   = CNT_LOAD;
                    end else begin
                        do_access  = 1'b1;
                        state_next = DONE;
                        err_next   = 1'b0;
                    end
                end
            end
            BUSY: begin
                if (cnt_reg == '0) begin
                    do_access  = 1'b1;
                    state_next = DONE;
                    err_next   = 1'b0;
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            DONE: begin
                if (!MFA) begin
                    state_next = IDLE;
                    err_next   = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Byte lanes: lane gi covers address acc_addr+gi; store data is first
    // shifted so its most significant used byte lands on lane 0 (big-endian).
    logic              store_en, load_en;
    logic [2:0]        lane_count;
    logic [31:0]       wdata_aligned;
    logic [ADDR_W-1:0] lane_addr  [4];
    logic [7:0]        lane_wdata [4];
    logic [7:0]        lane_rdata [4];
    logic [3:0]        lane_we;
    logic [31:0]       rd_word;
    logic [31:0]       load_value;

    assign store_en   = do_access && is_store;
    assign load_en    = do_access && !is_store;
    assign lane_count = 3'd1 << size_code;

    // Left-justify narrow store data
    always_comb begin
        case (size_code)
            SZ_WORD: wdata_aligned = acc_data;
            SZ_HALF: wdata_aligned = {acc_data[15:0], 16'h0000};
            default: wdata_aligned = {acc_data[7:0], 24'h000000};
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_addr[gi]  = acc_addr + ADDR_W'(gi);
            assign lane_wdata[gi] = wdata_aligned[31-8*gi -: 8];
            assign lane_we[gi]    = store_en && (3'(gi) < lane_count);
            assign lane_rdata[gi] = mem[lane_addr[gi]];
        end
    endgenerate

    assign rd_word = {lane_rdata[0], lane_rdata[1], lane_rdata[2], lane_rdata[3]};

    // Extend the addressed byte/halfword/word to 32 bits
    always_comb begin
        case (size_code)
            SZ_WORD: load_value = rd_word;
            SZ_HALF: load_value = {{16{is_signed & rd_word[31]}}, rd_word[31:16]};
            default: load_value = {{24{is_signed & rd_word[31]}}, rd_word[31:24]};
        endcase
    end

    // Control state, latched request and load result registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
            dout_reg  <= 32'h0;
            op_reg    <= '0;
            addr_reg  <= '0;
            din_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
            if (latch_en) begin
                op_reg   <= Opcode;
                addr_reg <= Address;
                din_reg  <= DataIn;
            end
            if (load_en) begin
                dout_reg <= load_value;
            end
        end
    end

    // Array write; contents survive reset but a reset edge blocks the write
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_we[i]) begin
                    mem[lane_addr[i]] <= lane_wdata[i];
                end
            end
        end
    end

    assign MFC     = (state_reg == DONE);
    assign Err     = err_reg;
    assign DataOut = dout_reg;

endmodule

// File: tb/tb_sparc_mem_unit.sv
// Scoreboard bench for sparc_mem_unit: one instance with two wait states,
// one with zero wait states, checked against a byte-array reference model.
module tb_sparc_mem_unit;

    typedef struct {
        logic [31:0] dout;
        logic        err;
        logic [5:0]  op;
        logic [7:0]  addr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mfa  [2];
    logic [5:0]  opc  [2];
    logic [7:0]  addr [2];
    logic [31:0] din  [2];
    logic [31:0] dout [2];
    logic        mfc  [2];
    logic        err  [2];

    int n_pass  = 0;
    int n_total = 0;

    exp_t q0[$];
    exp_t q1[$];

    // Reference state: byte arrays and last load result per unit
    logic [7:0]  ref_mem  [2][256];
    logic [31:0] ref_dout [2];

    always #5 clk = ~clk;

    sparc_mem_unit #(.ADDR_W(8), .WAIT_CYCLES(2)) dut (
        .Clk(clk), .Reset(reset), .MFA(mfa[0]), .Opcode(opc[0]), .Address(addr[0]),
        .DataIn(din[0]), .DataOut(dout[0]), .MFC(mfc[0]), .Err(err[0])
    );

    sparc_mem_unit #(.ADDR_W(8), .WAIT_CYCLES(0)) dut_zw (
        .Clk(clk), .Reset(reset), .MFA(mfa[1]), .Opcode(opc[1]), .Address(addr[1]),
        .DataIn(din[1]), .DataOut(dout[1]), .MFC(mfc[1]), .Err(err[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, want);
    endtask

    // Behavioural model: size/sign from opcode, big-endian byte arithmetic
    function automatic exp_t model_access(input int u, input logic [5:0] op,
                                          input logic [7:0] a, input logic [31:0] d);
        exp_t   e;
        int     size = 0;
        bit     st = 0;
        bit     sg = 0;
        longint v;
        case (op)
            6'h00: size = 4;
            6'h01: size = 1;
            6'h02: size = 2;
            6'h09: begin size = 1; sg = 1; end
            6'h0A: begin size = 2; sg = 1; end
            6'h04: begin size = 4; st = 1; end
            6'h05: begin size = 1; st = 1; end
            6'h06: begin size = 2; st = 1; end
            default: size = 0;
        endcase
        e.op   = op;
        e.addr = a;
        if (size == 0 || (int'(a) % size) != 0) begin
            e.err = 1'b1;
        end else begin
            e.err = 1'b0;
            if (st) begin
                for (int i = 0; i < size; i++)
                    ref_mem[u][(int'(a) + i) % 256] = 8'((d >> (8 * (size - 1 - i))) & 32'hFF);
            end else begin
                v = 0;
                for (int i = 0; i < size; i++)
                    v = v * 256 + longint'(ref_mem[u][(int'(a) + i) % 256]);
                if (sg && v >= (64'sd1 <<< (8 * size - 1)))
                    v = v - (64'sd1 <<< (8 * size));
                ref_dout[u] = 32'(v);
            end
        end
        e.dout = ref_dout[u];
        return e;
    endfunction

    // Issue one request, check latency and handshake; inputs are scrambled
    // after the request edge so only the latched values may matter.
    task automatic req(input int u, input logic [5:0] op, input logic [7:0] a,
                       input logic [31:0] d, input int hold);
        exp_t e;
        int   lat;
        int   want;
        e = model_access(u, op, a, d);
        if (u == 0) q0.push_back(e);
        else        q1.push_back(e);
        want = e.err ? 1 : ((u == 0) ? 3 : 1);
        @(posedge clk); #1;
        mfa[u] = 1'b1; opc[u] = op; addr[u] = a; din[u] = d;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            opc[u]  = 6'($urandom);
            addr[u] = 8'($urandom);
            din[u]  = $urandom;
            if (mfc[u]) break;
        end
        check("latency", 32'(lat), 32'(want));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check("mfc_hold", 32'(mfc[u]), 32'd1);
        end
        mfa[u] = 1'b0;
        @(posedge clk); #1;
        check("mfc_fall", 32'(mfc[u]), 32'd0);
    endtask

    // Monitor: on each MFC rise pop the expected response and compare
    logic mfc_prev [2] = '{1'b0, 1'b0};
    always @(negedge clk) begin
        exp_t e;
        for (int u = 0; u < 2; u++) begin
            if (mfc[u] && !mfc_prev[u]) begin
                if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
                    n_total++;
                    $display("FAIL unexpected_mfc unit%0d: got completion expected none", u);
                end else begin
                    e = (u == 0) ? q0.pop_front() : q1.pop_front();
                    check("dataout", dout[u], e.dout);
                    check("err", 32'(err[u]), 32'(e.err));
                    $display("unit%0d op=%h addr=%h dout=%h err=%b exp_dout=%h exp_err=%b",
                             u, e.op, e.addr, dout[u], err[u], e.dout, e.err);
                end
            end
            mfc_prev[u] = mfc[u];
        end
    end

    logic [5:0] legal_ops [8] = '{6'h00, 6'h01, 6'h02, 6'h09, 6'h0A, 6'h04, 6'h05, 6'h06};

    task automatic random_req(input int u);
        logic [5:0] op;
        logic [7:0] a;
        if ($urandom_range(0, 9) < 8) op = legal_ops[$urandom_range(0, 7)];
        else                          op = 6'($urandom);
        a = 8'($urandom);
        if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
        req(u, op, a, $urandom, int'($urandom_range(0, 2)));
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            mfa[u] = 1'b0; opc[u] = '0; addr[u] = '0; din[u] = '0;
            ref_dout[u] = 32'h0;
        end

        // Reset values, then idle with MFA low
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int u = 0; u < 2; u++) begin
            check("rst_mfc", 32'(mfc[u]), 32'd0);
            check("rst_err", 32'(err[u]), 32'd0);
            check("rst_dout", dout[u], 32'h0);
        end
        reset = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            check("idle_mfc", 32'(mfc[0]), 32'd0);
        end

        // Give every byte a known value
        for (int a = 0; a < 256; a += 4) begin
            req(0, 6'h04, 8'(a), $urandom, 0);
            req(1, 6'h04, 8'(a), $urandom, 0);
        end

        // Word round trip and extensions
        req(0, 6'h04, 8'd8,  32'hA2044012, 0);
        req(0, 6'h00, 8'd8,  32'h0, 0);
        req(0, 6'h01, 8'd8,  32'h0, 0);
        req(0, 6'h09, 8'd8,  32'h0, 0);
        req(0, 6'h02, 8'd10, 32'h0, 0);
        req(0, 6'h0A, 8'd10, 32'h0, 0);
        // Narrow stores
        req(0, 6'h05, 8'd9,  32'h123456FF, 0);
        req(0, 6'h00, 8'd8,  32'h0, 0);
        req(0, 6'h06, 8'd10, 32'h0000BEEF, 0);
        req(0, 6'h00, 8'd8,  32'h0, 0);
        // Errors leave memory and DataOut alone
        req(0, 6'h00, 8'd6,  32'h0, 0);
        req(0, 6'h3F, 8'd8,  32'h0, 0);
        req(0, 6'h06, 8'd3,  32'h5555AAAA, 0);
        req(0, 6'h04, 8'd2,  32'h5555AAAA, 0);
        req(0, 6'h00, 8'd0,  32'h0, 0);
        req(0, 6'h00, 8'd4,  32'h0, 0);
        // Held MFA keeps MFC high
        req(0, 6'h00, 8'd8,  32'h0, 5);

        // Reset while a store is in BUSY: no completion, no write
        @(posedge clk); #1;
        mfa[0] = 1'b1; opc[0] = 6'h04; addr[0] = 8'h20; din[0] = 32'hDEADBEEF;
        @(posedge clk); #1;
        check("busy_mfc", 32'(mfc[0]), 32'd0);
        reset = 1'b1; mfa[0] = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_dout", dout[0], 32'h0);
        repeat (4) begin
            @(posedge clk); #1;
            check("abort_mfc", 32'(mfc[0]), 32'd0);
        end
        ref_dout[0] = 32'h0;
        ref_dout[1] = 32'h0;
        req(0, 6'h00, 8'h20, 32'h0, 0);

        // Zero-wait instance
        req(1, 6'h04, 8'h40, 32'hCAFEF00D, 0);
        req(1, 6'h00, 8'h40, 32'h0, 0);
        req(1, 6'h0A, 8'h42, 32'h0, 1);
        req(1, 6'h02, 8'h41, 32'h0, 0);

        // Randomised traffic
        for (int i = 0; i < 150; i++) random_req(0);
        for (int i = 0; i < 80; i++)  random_req(1);

        repeat (3) @(posedge clk);
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sparc_mem_unit.md
# sparc_mem_unit

Parametrised byte-addressed data/instruction memory with an MFA/MFC request–complete handshake, programmable wait states, SPARC load/store size decoding (byte, halfword, word), sign/zero extension and alignment/illegal-opcode error reporting. It sits between the datapath's MAR/MDR registers and the memory array. It replaces the fixed 256-byte, untimed RAM model with a clocked, reset-able unit the control unit can stall on.

## Interface
Parameters:
- ADDR_W, 8, byte-address width; array depth = 2**ADDR_W bytes
- WAIT_CYCLES, 2, extra cycles spent in BUSY before the access completes (0 allowed)

Ports:
- Clk  in  1  single clock; all state changes on rising edge
- Reset  in  1  synchronous, active-high reset
- MFA  in  1  memory function activate (request); level, held until MFC seen
- Opcode  in  6  SPARC op3 field selecting access type
- Address  in  ADDR_W  byte address (from MAR)
- DataIn  in  32  store data (from MDR); the low byte or halfword is used for narrow stores
- DataOut  out  32  load result, extended to 32 bits
- MFC  out  1  memory function complete
- Err  out  1  access rejected (misaligned or illegal opcode); valid while MFC=1

## Operation
- Opcode decode:
  - 000000 LD: word load.
  - 000001 LDUB and 000010 LDUH: zero-extended loads.
  - 001001 LDSB and 001010 LDSH: sign-extended loads.
  - 000100 ST, 000101 STB, 000110 STH: stores.
  - Any other value is illegal.
- Byte order is big-endian.
  - Word at A: mem[A] is bits 31:24, mem[A+3] is bits 7:0.
  - Halfword at A: mem[A] is bits 15:8.
- Alignment rules:
  - Word accesses require Address[1:0]=00.
  - Halfword accesses require Address[0]=0.
  - Byte accesses are always aligned.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: when MFA=1 at an edge, latch Opcode, Address and DataIn, and check them.
    - If illegal or misaligned: go to DONE with Err=1. No array access, DataOut unchanged.
    - Otherwise, with WAIT_CYCLES>0: go to BUSY and load the wait counter with WAIT_CYCLES-1.
    - Otherwise, with WAIT_CYCLES=0: perform the access and go to DONE.
  - BUSY: count the wait counter down. When it is 0, perform the access using the latched values and go to DONE.
  - DONE: MFC=1. Stay while MFA=1. When MFA=0, go to IDLE (MFC=0 from that edge).
- Access effects:
  - A store writes its 1, 2 or 4 bytes at the completion edge. DataOut is not changed by a store.
  - A load registers the extended result into DataOut at the completion edge.
- Input changes after the request edge are ignored, because the latched values are used.
- The memory array is not cleared by Reset. Its contents are undefined until written.

## Timing
- Reset values: MFC=0, Err=0, DataOut=32'h0, state=IDLE, wait counter=0.
- Reset has priority over everything, including mid-BUSY or DONE.
  - A store aborted in BUSY never writes.
  - A store already completed (state DONE) stays written.
- Latency: request sampled at edge n gives MFC=1 after edge n+WAIT_CYCLES+1.
  - DataOut and Err are valid from that same edge.
  - Error requests always complete at edge n+1, whatever WAIT_CYCLES is.
- MFC falls on the first edge at which MFA=0 is sampled in DONE.
  - A new request is accepted no earlier than the following edge, when the unit is back in IDLE.
  - Minimum request spacing is WAIT_CYCLES+3 cycles.
- MFA=1 sampled in BUSY has no effect. MFA dropping during BUSY does not abort the access; MFC still pulses for one cycle at least.
- Address arithmetic is modulo 2**ADDR_W. Aligned accesses never wrap in practice, because the alignment checks forbid crossing the array end.

## Test plan
- Reset then idle: after Reset, MFC=0, Err=0, DataOut=0. Hold MFA=0 for 10 cycles; MFC stays 0.
- Word round-trip (WAIT_CYCLES=2):
  - ST 32'hA2044012 at address 8: MFC rises exactly 3 edges after the request.
  - LD from 8 returns 32'hA2044012.
  - LDUB from 8 returns 32'h000000A2.
  - LDSB from 8 returns 32'hFFFFFFA2.
  - LDUH from 10 returns 32'h00004012.
- Narrow stores:
  - STB of DataIn=32'h123456FF at address 9 leaves the word at 8 as 32'hA2FF4012.
  - STH of 32'h0000BEEF at address 10 gives 32'hA2FFBEEF.
- Errors:
  - LD at address 6 completes with Err=1 in 1 cycle and memory is unchanged.
  - Opcode 6'h3F completes with Err=1.
  - STH at address 3 completes with Err=1 and no write.
- Reset mid-BUSY: issue ST 32'hDEADBEEF at 0x20 and assert Reset during BUSY. MFC stays 0, and a later LD from 0x20 returns the prior contents.
- Handshake hold and zero-wait:
  - Keep MFA=1 for 5 cycles after MFC. MFC stays 1 throughout and falls one edge after MFA=0.
  - With WAIT_CYCLES=0, LD completes at edge n+1.
